// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer
//
// Per-channel controller for the conv -> relu -> pool pipeline of one CNN layer.
// Walks NUM_CHANNELS channels, holding cumulative stage enables until each stage
// reports done, with a per-stage watchdog that parks the block in an error state.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   start_i         begin a layer (honoured only when idle)
//   abort_i         cancel from any state, highest priority
//   conv_done_i     conv stage done level
//   relu_done_i     relu stage done level
//   pool_done_i     pool stage done level
//   conv_enable_o   conv stage enable
//   relu_enable_o   relu stage enable
//   pool_enable_o   pool stage enable
//   channel_idx_o   channel currently being processed
//   busy_o          high in every state but idle
//   layer_done_o    one-cycle pulse after the last channel
//   error_o         sticky watchdog flag, cleared only by abort or reset

module cnn_layer_sequencer #(
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned TIMEOUT      = 1024,
    parameter int unsigned CH_W         = 3,
    parameter int unsigned TO_W         = 10
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            conv_done_i,
    input  logic            relu_done_i,
    input  logic            pool_done_i,
    output logic            conv_enable_o,
    output logic            relu_enable_o,
    output logic            pool_enable_o,
    output logic [CH_W-1:0] channel_idx_o,
    output logic            busy_o,
    output logic            layer_done_o,
    output logic            error_o
);

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StRelu,
        StPool,
        StNext,
        StDone,
        StErr
    } state_e;

    localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CHANNELS - 1);
    // The watchdog reaches TIMEOUT-1 on the edge that leaves a cycle where it
    // reads TIMEOUT-2, so that is the cycle the timeout decision is made in.
    localparam logic [TO_W-1:0] WdogLimit = TO_W'(TIMEOUT - 2);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [TO_W-1:0]   wdog_q, wdog_d;
    logic              conv_en_q, relu_en_q, pool_en_q;
    logic              busy_q, layer_done_q, error_q;

    logic              done_ok;
    logic              timeout;
    logic              in_stage;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        wdog_d   = wdog_q;
        // A done seen in a stage's first cycle may be left over from before.
        done_ok  = (wdog_q != '0);
        timeout  = (wdog_q == WdogLimit);
        in_stage = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StConv;
                    ch_d    = '0;
                end
            end
            StConv: begin
                in_stage = 1'b1;
                if (conv_done_i && done_ok) state_d = StRelu;
                else if (timeout)           state_d = StErr;
            end
            StRelu: begin
                in_stage = 1'b1;
                if (relu_done_i && done_ok) state_d = StPool;
                else if (timeout)           state_d = StErr;
            end
            StPool: begin
                in_stage = 1'b1;
                if (pool_done_i && done_ok) state_d = StNext;
                else if (timeout)           state_d = StErr;
            end
            StNext: begin
                if (ch_q == LastCh) begin
                    state_d = StDone;
                end else begin
                    state_d = StConv;
                    ch_d    = ch_q + CH_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                ch_d    = '0;
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIdle;
                ch_d    = '0;
            end
        endcase

        if (abort_i) begin
            state_d = StIdle;
            ch_d    = '0;
        end

        if (state_d != state_q) wdog_d = '0;
        else if (in_stage)      wdog_d = wdog_q + TO_W'(1);
        else                    wdog_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            ch_q         <= '0;
            wdog_q       <= '0;
            conv_en_q    <= 1'b0;
            relu_en_q    <= 1'b0;
            pool_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            wdog_q       <= wdog_d;
            // Outputs are decoded from the next state so they line up with it.
            // Enables are cumulative: downstream stages zero out when upstream drops.
            conv_en_q    <= (state_d == StConv) || (state_d == StRelu) || (state_d == StPool);
            relu_en_q    <= (state_d == StRelu) || (state_d == StPool);
            pool_en_q    <= (state_d == StPool);
            busy_q       <= (state_d != StIdle);
            layer_done_q <= (state_d == StDone);
            error_q      <= (state_d == StErr);
        end
    end

    assign conv_enable_o = conv_en_q;
    assign relu_enable_o = relu_en_q;
    assign pool_enable_o = pool_en_q;
    assign channel_idx_o = ch_q;
    assign busy_o        = busy_q;
    assign layer_done_o  = layer_done_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer
//
// Directed bench for cnn_layer_sequencer (NUM_CHANNELS=8, TIMEOUT=16). Stage done
// inputs come either from an automatic responder (done 3 cycles after enable) or
// from hand-driven levels.

module tb_cnn_layer_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       abort_i;
    logic       conv_done_i, relu_done_i, pool_done_i;
    logic       conv_enable_o, relu_enable_o, pool_enable_o;
    logic [2:0] channel_idx_o;
    logic       busy_o, layer_done_o, error_o;

    cnn_layer_sequencer #(
        .NUM_CHANNELS(8),
        .TIMEOUT     (16),
        .CH_W        (3),
        .TO_W        (10)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .conv_done_i  (conv_done_i),
        .relu_done_i  (relu_done_i),
        .pool_done_i  (pool_done_i),
        .conv_enable_o(conv_enable_o),
        .relu_enable_o(relu_enable_o),
        .pool_enable_o(pool_enable_o),
        .channel_idx_o(channel_idx_o),
        .busy_o       (busy_o),
        .layer_done_o (layer_done_o),
        .error_o      (error_o)
    );

    always #5 clk_i = ~clk_i;

    // Responder: each done rises 3 cycles after its enable rises.
    bit auto_mode;
    bit m_conv, m_relu, m_pool;
    int conv_cnt = 0, relu_cnt = 0, pool_cnt = 0;

    always @(posedge clk_i) begin
        conv_cnt <= conv_enable_o ? conv_cnt + 1 : 0;
        relu_cnt <= relu_enable_o ? relu_cnt + 1 : 0;
        pool_cnt <= pool_enable_o ? pool_cnt + 1 : 0;
    end

    assign conv_done_i = auto_mode ? (conv_cnt >= 3) : m_conv;
    assign relu_done_i = auto_mode ? (relu_cnt >= 3) : m_relu;
    assign pool_done_i = auto_mode ? (pool_cnt >= 3) : m_pool;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int enables();
        return int'({conv_enable_o, relu_enable_o, pool_enable_o});
    endfunction

    task automatic kick();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // From the first CONV cycle, drive dones by hand until the first POOL cycle.
    task automatic goto_pool();
        m_conv = 1'b1;
        step();
        step();
        m_conv = 1'b0;
        m_relu = 1'b1;
        step();
        step();
        m_relu = 1'b0;
    endtask

    task automatic do_abort();
        m_conv  = 1'b0;
        m_relu  = 1'b0;
        m_pool  = 1'b0;
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
    endtask

    // Runs a layer already kicked off; t counts cycles after the start edge.
    task automatic run_layer(input bit pulse3, output int ld_t, output int busy_t,
                             output int nexts, output int lds, output bit seq_ok);
        int prev;
        bit pulsed;
        ld_t = -1; busy_t = -1; nexts = 0; lds = 0; seq_ok = 1'b1; prev = 0; pulsed = 1'b0;
        for (int t = 1; t <= 300; t++) begin
            if (pulse3 && !pulsed && channel_idx_o == 3'd3 && conv_enable_o) begin
                start_i = 1'b1;
                pulsed  = 1'b1;
            end
            step();
            start_i = 1'b0;
            if (busy_o) begin
                if (int'(channel_idx_o) != prev && int'(channel_idx_o) != prev + 1) seq_ok = 1'b0;
                prev = int'(channel_idx_o);
            end
            if (busy_o && enables() == 0 && !layer_done_o && !error_o) nexts++;
            if (layer_done_o) begin
                lds++;
                if (ld_t < 0) ld_t = t;
                if (channel_idx_o != 3'd7) seq_ok = 1'b0;
            end
            if (!busy_o) begin
                busy_t = t;
                break;
            end
        end
    endtask

    int ld_t, busy_t, nexts, lds, n, cnt;
    bit seq_ok;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        auto_mode = 1'b0; m_conv = 1'b0; m_relu = 1'b0; m_pool = 1'b0;
        repeat (3) step();
        chk("rst_enables", enables(), 0);
        chk("rst_ch", int'(channel_idx_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_ld", int'(layer_done_o), 0);
        chk("rst_err", int'(error_o), 0);
        rst_i = 1'b0;
        step();
        chk("idle_busy", int'(busy_o), 0);

        // Nominal layer: each stage 4 cycles, NEXT 1 => 13/channel, DONE at t=104.
        auto_mode = 1'b1;
        kick();
        chk("start_enables", enables(), 3'b100);
        chk("start_busy", int'(busy_o), 1);
        chk("start_ch", int'(channel_idx_o), 0);
        run_layer(1'b0, ld_t, busy_t, nexts, lds, seq_ok);
        chk("nom_ld_t", ld_t, 104);
        chk("nom_busy_t", busy_t, 105);
        chk("nom_nexts", nexts, 8);
        chk("nom_lds", lds, 1);
        chk("nom_seq", int'(seq_ok), 1);
        chk("nom_idle_ch", int'(channel_idx_o), 0);

        // Start in the first idle cycle after DONE; pulse start again at channel 3.
        kick();
        chk("restart_conv", enables(), 3'b100);
        chk("restart_ch", int'(channel_idx_o), 0);
        chk("restart_busy", int'(busy_o), 1);
        run_layer(1'b1, ld_t, busy_t, nexts, lds, seq_ok);
        chk("s3_ld_t", ld_t, 104);
        chk("s3_busy_t", busy_t, 105);
        chk("s3_nexts", nexts, 8);
        chk("s3_lds", lds, 1);
        chk("s3_seq", int'(seq_ok), 1);

        // Stale done levels.
        auto_mode = 1'b0;
        kick();
        m_relu = 1'b1;
        step();
        chk("conv_ignores_relu", enables(), 3'b100);
        m_conv = 1'b1;
        step();
        chk("relu_entered", enables(), 3'b110);
        step();
        chk("stale_relu_c2", enables(), 3'b110);
        step();
        chk("pool_after_relu", enables(), 3'b111);
        m_pool = 1'b1;
        step();
        step();
        chk("next_enables", enables(), 0);
        chk("next_busy", int'(busy_o), 1);
        step();
        chk("ch1_conv", enables(), 3'b100);
        chk("ch1_idx", int'(channel_idx_o), 1);
        step();
        step();
        chk("ch1_relu_entry", enables(), 3'b110);
        step();
        chk("ch1_relu_hold", enables(), 3'b110);
        step();
        chk("ch1_pool", enables(), 3'b111);
        do_abort();

        // Timeout in POOL.
        kick();
        goto_pool();
        chk("to_pool", enables(), 3'b111);
        n = 0;
        while (!error_o && n < 40) begin
            step();
            n++;
        end
        chk("to_cycles", n, 15);
        chk("to_enables", enables(), 0);
        chk("to_busy", int'(busy_o), 1);
        cnt = 0;
        repeat (50) begin
            step();
            if (error_o && busy_o && enables() == 0) cnt++;
        end
        chk("to_hold50", cnt, 50);
        do_abort();
        chk("to_abort_err", int'(error_o), 0);
        chk("to_abort_busy", int'(busy_o), 0);
        chk("to_abort_ch", int'(channel_idx_o), 0);

        // Done on the very cycle the watchdog expires.
        kick();
        goto_pool();
        repeat (14) step();
        m_pool = 1'b1;
        step();
        chk("race_err", int'(error_o), 0);
        chk("race_next", enables(), 0);
        chk("race_busy", int'(busy_o), 1);
        m_pool = 1'b0;
        step();
        chk("race_ch1", int'(channel_idx_o), 1);
        do_abort();

        // abort, then rst, together with conv_done at channel 5.
        for (int k = 0; k < 2; k++) begin
            auto_mode = 1'b1;
            kick();
            n = 0;
            while (channel_idx_o != 3'd5 && n < 200) begin
                step();
                n++;
            end
            chk(k == 0 ? "ab_reach5" : "rs_reach5", int'(channel_idx_o), 5);
            auto_mode = 1'b0;
            m_conv = 1'b1;
            step();
            if (k == 0) abort_i = 1'b1;
            else        rst_i   = 1'b1;
            step();
            abort_i = 1'b0;
            rst_i   = 1'b0;
            m_conv  = 1'b0;
            chk(k == 0 ? "ab_enables" : "rs_enables", enables(), 0);
            chk(k == 0 ? "ab_ch" : "rs_ch", int'(channel_idx_o), 0);
            chk(k == 0 ? "ab_busy" : "rs_busy", int'(busy_o), 0);
            cnt = 0;
            repeat (10) begin
                step();
                if (layer_done_o || busy_o) cnt++;
            end
            chk(k == 0 ? "ab_quiet" : "rs_quiet", cnt, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Per-channel controller for the conv → relu → pool pipeline of one CNN layer. It steps through `NUM_CHANNELS` feature-map channels, holding each stage's enable level until that stage reports done. A per-stage watchdog catches stalls, and the block reports `busy`, `layer_done` and `error` back to the top-level network FSM.

## Interface
- `NUM_CHANNELS`, default 8: channels processed per layer.
- `TIMEOUT`, default 1024: maximum cycles spent in any single stage.
- `CH_W`, default 3: width of `channel_idx`; must satisfy 2^CH_W ≥ NUM_CHANNELS.
- `TO_W`, default 10: watchdog counter width; must satisfy 2^TO_W ≥ TIMEOUT.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a layer; sampled only in IDLE.
- `abort`, in, 1: cancel from any state.
- `conv_done`, in, 1: level from the conv stage.
- `relu_done`, in, 1: level from the relu stage, registered and held while `relu_enable` is high.
- `pool_done`, in, 1: level from the pool stage.
- `conv_enable`, out, 1: conv stage enable (level).
- `relu_enable`, out, 1: relu stage enable (level).
- `pool_enable`, out, 1: pool stage enable (level).
- `channel_idx`, out, CH_W: channel currently being processed.
- `busy`, out, 1: high in every state except IDLE.
- `layer_done`, out, 1: one-cycle pulse when the last channel completes.
- `error`, out, 1: sticky watchdog flag.

## Operation
- States: IDLE, CONV, RELU, POOL, NEXT, DONE, ERR. All outputs are registered Moore outputs.
- Reset values: state IDLE; all enables 0; `channel_idx` 0; `busy` 0; `layer_done` 0; `error` 0; watchdog 0.
- IDLE: when `start`=1, go to CONV with `channel_idx`=0. `start` in any other state is ignored.
- Enables are cumulative, because downstream stages zero their outputs when their enable drops:
  - CONV: `conv_enable`=1.
  - RELU: `conv_enable`=`relu_enable`=1.
  - POOL: all three enables = 1.
- Transitions:
  - CONV → RELU on `conv_done`.
  - RELU → POOL on `relu_done`.
  - POOL → NEXT on `pool_done`.
- Stale-done guard: a stage's done is accepted only when the watchdog is ≥1, i.e. never in the first cycle of that state. Done inputs belonging to other stages are ignored.
- NEXT: all enables are 0 for exactly one cycle, so stage done flags clear.
  - If `channel_idx`==NUM_CHANNELS-1, go to DONE and keep `channel_idx` unchanged.
  - Otherwise increment `channel_idx` and go to CONV.
- DONE: `layer_done`=1 for one cycle, then IDLE, with `channel_idx` cleared to 0 on entry to IDLE.
- Watchdog:
  - Clears on every state entry and increments each cycle spent in CONV, RELU or POOL.
  - If it reaches TIMEOUT-1 with no accepted done, go to ERR.
  - A done that arrives in the same cycle as the timeout takes priority.
- ERR: all enables 0; `error`=1 (sticky); `busy`=1. Exit only via `abort` or `rst`.
- Abort:
  - Any state goes to IDLE on the next edge: enables 0, `channel_idx` 0, `error` cleared.
  - `abort` has priority over `start` and over any done input.
- `rst` mid-operation returns every output to its reset value on the next edge.

## Timing
- `start` sampled at edge 0 → `conv_enable`=1 and `busy`=1 from edge 1.
- Done sampled at edge k (watchdog ≥1) → next stage's enable is high from edge k+1.
- Minimum per-channel cost: 2 (CONV) + 2 (RELU) + 2 (POOL) + 1 (NEXT) = 7 cycles.
- Minimum layer: 7·NUM_CHANNELS + 1 (DONE) cycles from the first CONV cycle to the `layer_done` pulse.
- `busy` falls in the same cycle that IDLE is re-entered, i.e. one cycle after the `layer_done` pulse.
- ERR is entered exactly TIMEOUT-1 cycles after the stage was entered if no done arrives.

## Test plan
- Nominal flow: NUM_CHANNELS=8; each done returns 3 cycles after its enable rises.
  - Required: `channel_idx` steps 0..7; `layer_done` pulses once; `busy` falls one cycle later; 8 NEXT cycles are observed, each with all enables 0.
- Stale done: hold `relu_done`=1 through NEXT and into the first RELU cycle.
  - Required: the RELU state still lasts ≥2 cycles, and `pool_enable` never rises before `relu_done` is seen in cycle 2.
- Timeout: TIMEOUT=16; `pool_done` held at 0.
  - Required: ERR entered 15 cycles after POOL entry; all enables 0; `error`=1 held for 50 cycles.
  - Then `abort`: `error`=0, `busy`=0, `channel_idx`=0 on the next edge.
- Boundary race: `pool_done` asserted in the cycle the watchdog hits TIMEOUT-1.
  - Required: NEXT is taken, not ERR.
- Mid-layer interruption:
  - `abort` together with `conv_done` at channel 5 → IDLE, enables 0, `channel_idx` 0, no `layer_done`.
  - Repeat with `rst` instead of `abort` → identical result.
- `start` while busy:
  - Pulsing `start` at channel 3 has no effect: the channel sequence and `layer_done` timing are unchanged.
  - `start` in the cycle after DONE begins a new layer with `channel_idx`=0.
